// File: rtl/banked_mem_pkg.sv
// Shared definitions for the banked word memory: default geometry, state encoding
// and the lane write-mask helper.
package banked_mem_pkg;

  localparam int unsigned DEF_WORD_W    = 31;
  localparam int unsigned DEF_SLOT_W    = 32;
  localparam int unsigned DEF_LANE_W    = 2;
  localparam int unsigned DEF_ROW_AW    = 6;
  localparam int unsigned DEF_BANK_AW   = 4;
  localparam int unsigned DEF_NUM_BANKS = 8;

  localparam int unsigned ADDR_W     = DEF_BANK_AW + DEF_ROW_AW + DEF_LANE_W;
  localparam int unsigned ROW_W      = DEF_SLOT_W << DEF_LANE_W;
  localparam int unsigned CLEAR_ROWS = DEF_NUM_BANKS << DEF_ROW_AW;

  // Upper bound on a row width; callers truncate the mask to their own row width.
  localparam int unsigned MAX_ROW_W = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_CLEAR   = 3'd4
  } state_e;

  // Active-low bit-write mask enabling only the low word_w bits of one lane slot.
  function automatic logic [MAX_ROW_W-1:0] lane_bwen_n(input int unsigned lane,
                                                       input int unsigned slot_w,
                                                       input int unsigned word_w);
    logic [MAX_ROW_W-1:0] mask;
    mask = '1;
    for (int unsigned i = 0; i < MAX_ROW_W; i++) begin
      if ((i >= lane * slot_w) && (i < lane * slot_w + word_w)) begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/spram_bw.sv
// Single-port RAM with active-low chip/write/bit-write enables and one-cycle read
// latency; behavioural model standing in for the SRAM macro.
module spram_bw #(
  parameter int unsigned DEPTH_AW = 6,
  parameter int unsigned DATA_W   = 128
) (
  input  logic                clk,
  input  logic                cen_n,
  input  logic                wen_n,
  input  logic [DEPTH_AW-1:0] addr,
  input  logic [DATA_W-1:0]   d,
  input  logic [DATA_W-1:0]   bwen_n,
  output logic [DATA_W-1:0]   q
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_AW];
  logic [DATA_W-1:0] q_q;

  // Masked write keeps bits whose bwen_n is high; a read leaves q stable on writes.
  always_ff @(posedge clk) begin
    if (!cen_n) begin
      if (!wen_n) begin
        mem_q[addr] <= (mem_q[addr] & bwen_n) | (d & ~bwen_n);
      end else begin
        q_q <= mem_q[addr];
      end
    end
  end

  assign q = q_q;

endmodule

// File: rtl/banked_word_memory.sv
// Word-addressed store spread over NUM_BANKS bit-write SRAM banks, with a registered
// request/finish handshake, held read data, out-of-range error and bulk clear.
module banked_word_memory
  import banked_mem_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned SLOT_W    = DEF_SLOT_W,
  parameter int unsigned LANE_W    = DEF_LANE_W,
  parameter int unsigned ROW_AW    = DEF_ROW_AW,
  parameter int unsigned BANK_AW   = DEF_BANK_AW,
  parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
  localparam int unsigned MEM_AW     = BANK_AW + ROW_AW + LANE_W,
  localparam int unsigned MEM_RW     = SLOT_W << LANE_W,
  localparam int unsigned SWEEP_ROWS = NUM_BANKS << ROW_AW,
  localparam int unsigned CNT_W      = BANK_AW + ROW_AW
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic [MEM_AW-1:0] addr,
  input  logic [WORD_W-1:0] write_data,
  output logic [WORD_W-1:0] read_data,
  output logic              finish,
  output logic              error,
  input  logic              clear_start,
  output logic              clear_busy
);

  state_e             state_q, state_d;
  logic [BANK_AW-1:0] bank_q, bank_d;
  logic [ROW_AW-1:0]  row_q, row_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic               is_write_q, is_write_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  read_data_q, read_data_d;
  logic               finish_q, finish_d;
  logic               error_q, error_d;
  logic               clear_busy_q, clear_busy_d;

  logic                 oob_c;
  logic                 acc_active;
  logic                 acc_we;
  logic [BANK_AW-1:0]   sel_bank;
  logic [ROW_AW-1:0]    sram_row;
  logic [MEM_RW-1:0]    sram_d;
  logic [MEM_RW-1:0]    sram_bwen_n;
  logic [NUM_BANKS-1:0] bank_cen_n;
  logic [NUM_BANKS-1:0] bank_wen_n;
  logic [MEM_RW-1:0]    q_bank [NUM_BANKS];
  logic [MEM_RW-1:0]    sel_row;
  logic [SLOT_W-1:0]    lane_slot;

  assign oob_c = ({1'b0, bank_q} >= (BANK_AW + 1)'(NUM_BANKS));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      bank_q       <= '0;
      row_q        <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      is_write_q   <= 1'b0;
      cnt_q        <= '0;
      read_data_q  <= '0;
      finish_q     <= 1'b0;
      error_q      <= 1'b0;
      clear_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      row_q        <= row_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      is_write_q   <= is_write_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      finish_q     <= finish_d;
      error_q      <= error_d;
      clear_busy_q <= clear_busy_d;
    end
  end

  // Next state and request latch; clear wins over an access, write over a read.
  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    row_d      = row_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (write_enable || read_enable) begin
          state_d                  = ST_ACCESS;
          {bank_d, row_d, lane_d}  = addr;
          wdata_d                  = write_data;
          is_write_d               = write_enable;
        end
      end
      ST_ACCESS:  state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      ST_CLEAR: begin
        if (cnt_q == CNT_W'(SWEEP_ROWS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bank drive, read-data capture and registered handshake outputs.
  always_comb begin
    acc_active   = 1'b0;
    acc_we       = 1'b0;
    sel_bank     = bank_q;
    sram_row     = row_q;
    sram_d       = {(1 << LANE_W){SLOT_W'(wdata_q)}};
    sram_bwen_n  = '1;
    read_data_d  = read_data_q;
    finish_d     = 1'b0;
    error_d      = 1'b0;
    clear_busy_d = (state_d == ST_CLEAR);

    sel_row = '0;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      if (bank_q == BANK_AW'(b)) sel_row = q_bank[b];
    end
    lane_slot = sel_row[32'(lane_q) * SLOT_W +: SLOT_W];

    unique case (state_q)
      ST_ACCESS: begin
        acc_active = !oob_c;
        acc_we     = is_write_q;
        if (is_write_q) begin
          sram_bwen_n = MEM_RW'(lane_bwen_n(32'(lane_q), SLOT_W, WORD_W));
        end
      end
      ST_CAPTURE: begin
        if (!is_write_q && !oob_c) read_data_d = lane_slot[WORD_W-1:0];
      end
      ST_DONE: begin
        finish_d = 1'b1;
        error_d  = oob_c;
      end
      ST_CLEAR: begin
        acc_active  = 1'b1;
        acc_we      = 1'b1;
        sel_bank    = cnt_q[CNT_W-1:ROW_AW];
        sram_row    = cnt_q[ROW_AW-1:0];
        sram_d      = '0;
        sram_bwen_n = '0;
      end
      default: ;
    endcase

    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      bank_cen_n[b] = !(acc_active && (sel_bank == BANK_AW'(b)));
      bank_wen_n[b] = !(acc_active && acc_we && (sel_bank == BANK_AW'(b)));
    end
  end

  for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
    spram_bw #(
      .DEPTH_AW(ROW_AW),
      .DATA_W  (MEM_RW)
    ) u_ram (
      .clk   (clk),
      .cen_n (bank_cen_n[b]),
      .wen_n (bank_wen_n[b]),
      .addr  (sram_row),
      .d     (sram_d),
      .bwen_n(sram_bwen_n),
      .q     (q_bank[b])
    );
  end

  // Slot pad bits never reach the read word.
  if (SLOT_W > WORD_W) begin : g_pad
    logic pad_unused;
    assign pad_unused = ^lane_slot[SLOT_W-1:WORD_W];
  end

  assign read_data  = read_data_q;
  assign finish     = finish_q;
  assign error      = error_q;
  assign clear_busy = clear_busy_q;

endmodule

// File: tb/tb_banked_word_memory.sv
// Directed bench for banked_word_memory: a word-array model predicts read data,
// finish/error timing and clear behaviour; every cycle is compared against it.
module tb_banked_word_memory;

  logic        clk;
  logic        resetn;
  logic        write_enable;
  logic        read_enable;
  logic [11:0] addr;
  logic [30:0] write_data;
  logic [30:0] read_data;
  logic        finish;
  logic        error;
  logic        clear_start;
  logic        clear_busy;

  int checks   = 0;
  int failures = 0;

  logic [30:0] mdl   [4096];
  bit          known [4096];

  logic [30:0] exp_rd;
  bit          exp_fin;
  bit          exp_err;
  bit          exp_busy;

  banked_word_memory dut (
    .clk         (clk),
    .resetn      (resetn),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .addr        (addr),
    .write_data  (write_data),
    .read_data   (read_data),
    .finish      (finish),
    .error       (error),
    .clear_start (clear_start),
    .clear_busy  (clear_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // One clock; outputs compared against the model just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("finish", 64'(finish), 64'(exp_fin));
    if (exp_fin) chk("error", 64'(error), 64'(exp_err));
    chk("read_data", 64'(read_data), 64'(exp_rd));
    chk("clear_busy", 64'(clear_busy), 64'(exp_busy));
  endtask

  // Full request: sampled at E0, finish expected during the cycle after E3.
  task automatic access(input bit we, input bit re, input logic [11:0] a, input logic [30:0] d);
    bit          oob;
    logic [30:0] nxt_rd;
    oob    = (a[11:8] >= 4'd8);
    nxt_rd = exp_rd;
    if (we) begin
      if (!oob) begin
        mdl[a]   = d;
        known[a] = 1'b1;
      end
    end else if (!oob && known[a]) begin
      nxt_rd = mdl[a];
    end
    write_enable = we;
    read_enable  = re;
    addr         = a;
    write_data   = d;
    exp_fin      = 1'b0;
    tick();
    tick();
    exp_rd = nxt_rd;
    tick();
    exp_fin = 1'b1;
    exp_err = oob;
    tick();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    exp_fin      = 1'b0;
    tick();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) begin
      if (i < 2048) begin
        mdl[i]   = '0;
        known[i] = 1'b1;
      end
    end
  endtask

  initial begin
    int busy_cnt;
    logic [11:0] lane_addr;

    resetn       = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    addr         = '0;
    write_data   = '0;
    clear_start  = 1'b0;
    exp_rd       = '0;
    exp_fin      = 1'b0;
    exp_err      = 1'b0;
    exp_busy     = 1'b0;
    for (int i = 0; i < 4096; i++) known[i] = 1'b0;

    tick();
    tick();
    chk("reset_read_data", 64'(read_data), 64'h0);
    chk("reset_busy", 64'(clear_busy), 64'h0);
    resetn = 1'b1;
    tick();

    // Basic write/read with fixed latency.
    access(1'b1, 1'b0, 12'h123, 31'h2345_6789);
    access(1'b0, 1'b1, 12'h123, 31'h0);
    chk("rd_0x123", 64'(read_data), 64'h2345_6789);

    // Four lanes of one row, each read back independently.
    for (int i = 0; i < 4; i++) begin
      lane_addr = 12'h214 + 12'(i);
      access(1'b1, 1'b0, lane_addr, 31'(8'h11 * (i + 1)));
    end
    for (int i = 0; i < 4; i++) begin
      lane_addr = 12'h214 + 12'(i);
      access(1'b0, 1'b1, lane_addr, 31'h0);
      chk("rd_lane", 64'(read_data), 64'(8'h11 * (i + 1)));
    end

    // Out-of-range bank: error with finish, read data held.
    access(1'b1, 1'b0, 12'h100, 31'h0ABC);
    access(1'b0, 1'b1, 12'h123, 31'h0);
    access(1'b1, 1'b0, 12'h900, 31'h7FFF_FFFF);
    access(1'b0, 1'b1, 12'h900, 31'h0);
    chk("rd_held_after_oob", 64'(read_data), 64'h2345_6789);
    access(1'b0, 1'b1, 12'h100, 31'h0);
    chk("rd_0x100", 64'(read_data), 64'h0ABC);

    // Both enables: treated as a write.
    access(1'b1, 1'b1, 12'h010, 31'h5);
    chk("rd_held_after_dual", 64'(read_data), 64'h0ABC);
    access(1'b0, 1'b1, 12'h010, 31'h0);
    chk("rd_0x010", 64'(read_data), 64'h5);

    // Bulk clear; requests and a second clear_start during the sweep are ignored.
    clear_start = 1'b1;
    exp_busy    = 1'b1;
    tick();
    clear_start = 1'b0;
    busy_cnt    = clear_busy ? 1 : 0;
    for (int i = 1; i < 512; i++) begin
      if (i == 50) begin
        write_enable = 1'b1;
        addr         = 12'h123;
        write_data   = 31'h1;
      end
      if (i == 200) write_enable = 1'b0;
      if (i == 300) clear_start = 1'b1;
      if (i == 301) clear_start = 1'b0;
      tick();
      if (clear_busy) busy_cnt++;
    end
    exp_busy = 1'b0;
    tick();
    chk("clear_busy_cycles", 64'(busy_cnt), 64'd512);
    model_clear();
    access(1'b0, 1'b1, 12'h123, 31'h0);
    chk("rd_cleared_0x123", 64'(read_data), 64'h0);
    access(1'b0, 1'b1, 12'h216, 31'h0);
    access(1'b0, 1'b1, 12'h010, 31'h0);
    access(1'b0, 1'b1, 12'h7FF, 31'h0);
    chk("rd_cleared_0x7ff", 64'(read_data), 64'h0);

    // Reset in the middle of a clear.
    access(1'b1, 1'b0, 12'h7C1, 31'h3ABC_DEF);
    access(1'b0, 1'b1, 12'h7C1, 31'h0);
    chk("rd_0x7c1", 64'(read_data), 64'h3ABC_DEF);
    clear_start = 1'b1;
    exp_busy    = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 1; i < 100; i++) tick();
    resetn = 1'b0;
    #1;
    chk("async_rst_read_data", 64'(read_data), 64'h0);
    chk("async_rst_busy", 64'(clear_busy), 64'h0);
    chk("async_rst_finish", 64'(finish), 64'h0);
    chk("async_rst_error", 64'(error), 64'h0);
    exp_rd   = '0;
    exp_busy = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      if ((i >> 2) <= 102) known[i] = 1'b0;
    end
    tick();
    resetn = 1'b1;
    tick();
    access(1'b0, 1'b1, 12'h7C1, 31'h0);
    chk("rd_intact_0x7c1", 64'(read_data), 64'h3ABC_DEF);
    access(1'b1, 1'b0, 12'h010, 31'h77);
    access(1'b0, 1'b1, 12'h010, 31'h0);
    chk("rd_after_reset_0x010", 64'(read_data), 64'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
